// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants for VGA 640x480@60. These values are the default
// parameters of vga_sync_gen. Any block that needs the raster geometry
// imports this package instead of repeating the numbers.
//
// Contents:
//   CNT_W                - width of the raster counters and pixel coordinates
//   H_* / V_*            - visible, front porch, sync and back porch lengths
//   H_TOTAL / V_TOTAL    - full line length (pixels) and frame length (lines)
//   inWindow()           - half-open range test used by the sync/video decode
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // True when lo <= value < hi. Every timing window in the raster is
  // described this way, so the decode reads the same as the timing table.
  function automatic logic inWindow(input int value, input int lo, input int hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Modulo-N up-counter with enable and asynchronous reset. vga_sync_gen uses
// one instance for the horizontal pixel count and one for the vertical
// line count.
//
// Parameters:
//   WIDTH    - counter width
//   MODULUS  - count sequence is 0 .. MODULUS-1, then back to 0
//
// Ports:
//   clock     in   clock
//   reset     in   asynchronous, active-high reset (count -> 0)
//   i_enable  in   advance the count on this clock edge
//   o_count   out  current registered count
//   o_next    out  value the count takes on the next edge (equals o_count
//                  when i_enable is low); lets downstream logic register
//                  decodes that line up with the count itself
//   o_wrap    out  count is at its terminal value, so the next enabled edge
//                  returns it to 0
// ---------------------------------------------------------------------------
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             w_atLast;

  // ">=" instead of "==" so a count that is somehow out of range (for
  // example after an SEU) still falls back to 0 on the next enable rather
  // than running all the way round the counter width.
  assign w_atLast = (r_count >= LAST);

  always_comb begin
    o_next = r_count;
    if (i_enable) begin
      o_next = w_atLast ? '0 : r_count + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= o_next;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = w_atLast;

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// VGA raster timing generator (640x480@60 by default). It runs on the fast
// system clock and advances one pixel per pixel_en pulse from the divide-by-4
// pixel clock stage. It drives the colour generator and the connector pins.
//
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous, active-high reset
//   pixel_en    in   one-clock pixel enable pulse
//   hsync       out  horizontal sync, asserted level = SYNC_ACTIVE
//   vsync       out  vertical sync, asserted level = SYNC_ACTIVE
//   video_on    out  inside the visible area
//   pixel_x     out  raw horizontal count, including blanking
//   pixel_y     out  raw vertical count, including blanking
//   line_tick   out  one-clock pulse after the horizontal count wraps to 0
//   frame_tick  out  one-clock pulse after the raster wraps to (0,0)
//
// pixel_x/pixel_y keep counting through blanking, so consumers must gate
// them with video_on.
// ---------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BACK      = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BACK      = vga_timing_pkg::V_BACK,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int CNT_W       = vga_timing_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pixel_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_tick,
  output logic             frame_tick
);

  localparam int H_PERIOD   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_PERIOD   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START   = H_VISIBLE + H_FRONT;
  localparam int HS_END     = HS_START + H_SYNC;
  localparam int VS_START   = V_VISIBLE + V_FRONT;
  localparam int VS_END     = VS_START + V_SYNC;

  logic [CNT_W-1:0] w_hCnt;
  logic [CNT_W-1:0] w_hNext;
  logic             w_hWrap;
  logic [CNT_W-1:0] w_vCnt;
  logic [CNT_W-1:0] w_vNext;
  logic             w_vWrap;
  logic             w_vEnable;
  logic             w_frameEnd;

  logic             w_hsyncNext;
  logic             w_vsyncNext;
  logic             w_videoOnNext;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_videoOn;
  logic             r_lineTick;
  logic             r_frameTick;

  mod_counter #(
    .WIDTH   (CNT_W),
    .MODULUS (H_PERIOD)
  ) uHCounter (
    .clock    (clock),
    .reset    (reset),
    .i_enable (pixel_en),
    .o_count  (w_hCnt),
    .o_next   (w_hNext),
    .o_wrap   (w_hWrap)
  );

  // The line counter only moves on the pixel that ends a line.
  assign w_vEnable  = pixel_en & w_hWrap;
  assign w_frameEnd = w_vEnable & w_vWrap;

  mod_counter #(
    .WIDTH   (CNT_W),
    .MODULUS (V_PERIOD)
  ) uVCounter (
    .clock    (clock),
    .reset    (reset),
    .i_enable (w_vEnable),
    .o_count  (w_vCnt),
    .o_next   (w_vNext),
    .o_wrap   (w_vWrap)
  );

  // Decode from the counters' next values. The registered results then
  // change on the same edge as pixel_x/pixel_y, with no added latency.
  // When pixel_en is low the next values equal the current ones, so the
  // registers simply reload what they already hold.
  always_comb begin
    w_hsyncNext   = ~SYNC_ACTIVE;
    w_vsyncNext   = ~SYNC_ACTIVE;
    w_videoOnNext = 1'b0;
    if (inWindow(int'(w_hNext), HS_START, HS_END)) begin
      w_hsyncNext = SYNC_ACTIVE;
    end
    if (inWindow(int'(w_vNext), VS_START, VS_END)) begin
      w_vsyncNext = SYNC_ACTIVE;
    end
    if (inWindow(int'(w_hNext), 0, H_VISIBLE) &&
        inWindow(int'(w_vNext), 0, V_VISIBLE)) begin
      w_videoOnNext = 1'b1;
    end
  end

  // Reset lands on raster position (0,0), which is visible and outside
  // both sync windows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hsync   <= ~SYNC_ACTIVE;
      r_vsync   <= ~SYNC_ACTIVE;
      r_videoOn <= 1'b1;
    end else begin
      r_hsync   <= w_hsyncNext;
      r_vsync   <= w_vsyncNext;
      r_videoOn <= w_videoOnNext;
    end
  end

  // The ticks are taken from the wrap enables rather than from "count == 0".
  // That way they last exactly one clock even when pixel_en is held low and
  // the raster parks at 0. A frame wrap is always also a line wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lineTick  <= 1'b0;
      r_frameTick <= 1'b0;
    end else begin
      r_lineTick  <= w_vEnable;
      r_frameTick <= w_frameEnd;
    end
  end

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign video_on   = r_videoOn;
  assign pixel_x    = w_hCnt;
  assign pixel_y    = w_vCnt;
  assign line_tick  = r_lineTick;
  assign frame_tick = r_frameTick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
// Two instances: dutA uses the default 640x480 timing with active-low sync.
// dutB uses a miniature raster (16x11) with active-high sync, so that whole
// frames and mid-frame resets can be exercised in a few hundred clocks.
// A behavioural raster model predicts every output. Its predictions are
// queued when a clock's stimulus is driven and popped and compared after
// the edge.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  logic       clock = 1'b0;
  logic       resetA = 1'b1;
  logic       resetB = 1'b1;
  logic       pixelEnA = 1'b0;
  logic       pixelEnB = 1'b0;

  logic       hsyncA, vsyncA, videoOnA, lineTickA, frameTickA;
  logic [9:0] pixelXA, pixelYA;
  logic       hsyncB, vsyncB, videoOnB, lineTickB, frameTickB;
  logic [9:0] pixelXB, pixelYB;

  int assertCount = 0;
  int failCount   = 0;

  // Model state, index 0 = dutA, 1 = dutB
  int   mh[2];
  int   mv[2];
  logic mlt[2];
  logic mft[2];

  logic [31:0] qA[$];
  logic [31:0] qB[$];

  always #5 clock = ~clock;

  vga_sync_gen dutA (
    .clock      (clock),
    .reset      (resetA),
    .pixel_en   (pixelEnA),
    .hsync      (hsyncA),
    .vsync      (vsyncA),
    .video_on   (videoOnA),
    .pixel_x    (pixelXA),
    .pixel_y    (pixelYA),
    .line_tick  (lineTickA),
    .frame_tick (frameTickA)
  );

  vga_sync_gen #(
    .H_VISIBLE   (8),
    .H_FRONT     (2),
    .H_SYNC      (3),
    .H_BACK      (3),
    .V_VISIBLE   (6),
    .V_FRONT     (1),
    .V_SYNC      (2),
    .V_BACK      (2),
    .SYNC_ACTIVE (1'b1),
    .CNT_W       (10)
  ) dutB (
    .clock      (clock),
    .reset      (resetB),
    .pixel_en   (pixelEnB),
    .hsync      (hsyncB),
    .vsync      (vsyncB),
    .video_on   (videoOnB),
    .pixel_x    (pixelXB),
    .pixel_y    (pixelYB),
    .line_tick  (lineTickB),
    .frame_tick (frameTickB)
  );

  function automatic logic [31:0] packOut(input logic [9:0] x, input logic [9:0] y,
                                          input logic hs, input logic vs, input logic von,
                                          input logic lt, input logic ft);
    return {7'd0, x, y, hs, vs, von, lt, ft};
  endfunction

  // Raster geometry, written out from the timing table:
  // A: 800 x 525, hsync 656..751, vsync 490..491, visible 640x480, active-low
  // B: 16 x 11,   hsync 10..12,   vsync 7..8,     visible 8x6,     active-high
  function automatic logic [31:0] expectedOut(input int d);
    int   hTot, hsLo, hsHi, vsLo, vsHi, hVis, vVis;
    logic act, hs, vs, von;
    if (d == 0) begin
      hTot = 800; hsLo = 656; hsHi = 751; vsLo = 490; vsHi = 491;
      hVis = 640; vVis = 480; act = 1'b0;
    end else begin
      hTot = 16; hsLo = 10; hsHi = 12; vsLo = 7; vsHi = 8;
      hVis = 8; vVis = 6; act = 1'b1;
    end
    hs  = (mh[d] >= hsLo && mh[d] <= hsHi) ? act : ~act;
    vs  = (mv[d] >= vsLo && mv[d] <= vsHi) ? act : ~act;
    von = (mh[d] < hVis) && (mv[d] < vVis);
    return packOut(10'(mh[d]), 10'(mv[d]), hs, vs, von, mlt[d], mft[d]);
  endfunction

  task automatic modelAdvance(input int d, input logic en);
    int hTot, vTot;
    hTot = (d == 0) ? 800 : 16;
    vTot = (d == 0) ? 525 : 11;
    mlt[d] = 1'b0;
    mft[d] = 1'b0;
    if (en) begin
      if (mh[d] == hTot - 1) begin
        mh[d]  = 0;
        mlt[d] = 1'b1;
        if (mv[d] == vTot - 1) begin
          mv[d]  = 0;
          mft[d] = 1'b1;
        end else begin
          mv[d] = mv[d] + 1;
        end
      end else begin
        mh[d] = mh[d] + 1;
      end
    end
  endtask

  task automatic modelReset(input int d);
    mh[d]  = 0;
    mv[d]  = 0;
    mlt[d] = 1'b0;
    mft[d] = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock: drive both enables, queue the predictions, then compare
  // after the edge.
  task automatic applyStimulus(input logic enA, input logic enB);
    pixelEnA = enA;
    pixelEnB = enB;
    modelAdvance(0, enA);
    modelAdvance(1, enB);
    qA.push_back(expectedOut(0));
    qB.push_back(expectedOut(1));
    @(posedge clock);
    #1;
    checkOutput("A.outs", packOut(pixelXA, pixelYA, hsyncA, vsyncA, videoOnA,
                                  lineTickA, frameTickA), qA.pop_front());
    checkOutput("B.outs", packOut(pixelXB, pixelYB, hsyncB, vsyncB, videoOnB,
                                  lineTickB, frameTickB), qB.pop_front());
  endtask

  initial begin
    int hsLowCnt, firstLowX, lineTickCnt;
    int vsHighCnt, hsHighCnt, vonCnt, frameTickCnt, ftX, ftY, ltCntB;

    modelReset(0);
    modelReset(1);

    // Reset state while reset is held
    repeat (2) @(posedge clock);
    #1;
    checkOutput("A.reset", packOut(pixelXA, pixelYA, hsyncA, vsyncA, videoOnA,
                                   lineTickA, frameTickA),
                packOut(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    checkOutput("B.reset", packOut(pixelXB, pixelYB, hsyncB, vsyncB, videoOnB,
                                   lineTickB, frameTickB),
                packOut(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    resetA = 1'b0;
    resetB = 1'b0;

    // First pixel after reset, then three idle clocks
    hsLowCnt = 0; firstLowX = -1; lineTickCnt = 0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("A.firstX", 32'(pixelXA), 32'd1);
    checkOutput("A.firstY", 32'(pixelYA), 32'd0);
    checkOutput("A.firstSync", {29'd0, videoOnA, hsyncA, vsyncA}, 32'b111);
    if (hsyncA == 1'b0) begin
      hsLowCnt++;
    end
    repeat (3) begin
      applyStimulus(1'b0, 1'b0);
      if (lineTickA) lineTickCnt++;
    end
    checkOutput("A.idleHoldX", 32'(pixelXA), 32'd1);

    // Rest of the first line at one pulse per four clocks
    for (int p = 1; p < 800; p++) begin
      applyStimulus(1'b1, 1'b0);
      if (lineTickA) lineTickCnt++;
      if (hsyncA == 1'b0) begin
        if (hsLowCnt == 0) firstLowX = int'(pixelXA);
        hsLowCnt++;
      end
      repeat (3) begin
        applyStimulus(1'b0, 1'b0);
        if (lineTickA) lineTickCnt++;
      end
    end
    checkOutput("A.hsyncLowPulses", 32'(hsLowCnt), 32'd96);
    checkOutput("A.hsyncFirstX", 32'(firstLowX), 32'd656);
    checkOutput("A.lineTicks", 32'(lineTickCnt), 32'd1);
    checkOutput("A.lineEndX", 32'(pixelXA), 32'd0);
    checkOutput("A.lineEndY", 32'(pixelYA), 32'd1);

    // pixel_en held high up to x = 639, then frozen for 100 clocks
    for (int p = 0; p < 639; p++) begin
      applyStimulus(1'b1, 1'b0);
    end
    checkOutput("A.at639", 32'(pixelXA), 32'd639);
    repeat (100) applyStimulus(1'b0, 1'b0);
    checkOutput("A.frozenX", 32'(pixelXA), 32'd639);
    checkOutput("A.frozenVideo", 32'(videoOnA), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("A.x640", 32'(pixelXA), 32'd640);
    checkOutput("A.blank640", 32'(videoOnA), 32'd0);

    // dutB: one complete frame with pixel_en held high
    vsHighCnt = 0; hsHighCnt = 0; vonCnt = 0; frameTickCnt = 0;
    ftX = -1; ftY = -1; ltCntB = 0;
    for (int p = 0; p < 176; p++) begin
      applyStimulus(1'b0, 1'b1);
      if (vsyncB) vsHighCnt++;
      if (hsyncB) hsHighCnt++;
      if (videoOnB) vonCnt++;
      if (lineTickB) ltCntB++;
      if (frameTickB) begin
        frameTickCnt++;
        ftX = int'(pixelXB);
        ftY = int'(pixelYB);
      end
    end
    checkOutput("B.vsyncHigh", 32'(vsHighCnt), 32'd32);
    checkOutput("B.hsyncHigh", 32'(hsHighCnt), 32'd33);
    checkOutput("B.videoOnCount", 32'(vonCnt), 32'd48);
    checkOutput("B.lineTicks", 32'(ltCntB), 32'd11);
    checkOutput("B.frameTicks", 32'(frameTickCnt), 32'd1);
    checkOutput("B.frameTickPos", {ftX[15:0], ftY[15:0]}, 32'd0);

    // Advance to (11,4), inside hsync, then reset between clock edges
    for (int p = 0; p < 75; p++) begin
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("B.preResetPos", {6'd0, pixelXB, 6'd0, pixelYB}, {6'd0, 10'd11, 6'd0, 10'd4});
    checkOutput("B.preResetHsync", 32'(hsyncB), 32'd1);
    pixelEnB = 1'b0;
    #2;
    resetB = 1'b1;
    #1;
    checkOutput("B.asyncReset", packOut(pixelXB, pixelYB, hsyncB, vsyncB, videoOnB,
                                        lineTickB, frameTickB),
                packOut(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    @(posedge clock);
    #1;
    modelReset(1);
    resetB = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("B.restartX", 32'(pixelXB), 32'd1);
    applyStimulus(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
